// File: rtl/alu_pkg.sv
// Shared types and constants for the pipelined ALU.
package alu_pkg;

   localparam int ALU_WIDTH = 32;

   // Operation select codes carried on ALUCtrl_i.
   typedef enum logic [2:0] {
      OP_AND  = 3'b000,
      OP_OR   = 3'b001,
      OP_ADD  = 3'b010,
      OP_XOR  = 3'b011,
      OP_NOR  = 3'b100,
      OP_SLTU = 3'b101,
      OP_SUB  = 3'b110,
      OP_SLT  = 3'b111
   } alu_op_e;

   // One computed result with its flags.
   typedef struct packed {
      logic [ALU_WIDTH-1:0] result;
      logic                 zero;
      logic                 ovf;
   } alu_res_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU datapath: result, zero and signed-overflow flags.
import alu_pkg::*;

module alu_core (
   input  logic [ALU_WIDTH-1:0] a,
   input  logic [ALU_WIDTH-1:0] b,
   input  alu_op_e              op,
   output alu_res_t             res
);

   logic [ALU_WIDTH-1:0] sum;
   logic [ALU_WIDTH-1:0] diff;
   logic                 sa;
   logic                 sb;

   // Shared adder/subtractor outputs; carry-out is discarded (modulo 2^W).
   always_comb begin
      sum  = a + b;
      diff = a - b;
      sa   = a[ALU_WIDTH-1];
      sb   = b[ALU_WIDTH-1];
   end

   // Select the result per op; overflow is only meaningful for ADD/SUB.
   always_comb begin
      res = '0;
      unique case (op)
         OP_AND:  res.result = a & b;
         OP_OR:   res.result = a | b;
         OP_XOR:  res.result = a ^ b;
         OP_NOR:  res.result = ~(a | b);
         OP_ADD: begin
            res.result = sum;
            res.ovf    = (sa == sb) && (sum[ALU_WIDTH-1] != sa);
         end
         OP_SUB: begin
            res.result = diff;
            res.ovf    = (sa != sb) && (diff[ALU_WIDTH-1] != sa);
         end
         OP_SLTU: res.result = (a < b) ? ALU_WIDTH'(1) : '0;
         OP_SLT:  res.result = ($signed(a) < $signed(b)) ? ALU_WIDTH'(1) : '0;
         default: res.result = '0;
      endcase
      res.zero = (res.result == '0);
   end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage ALU pipeline with valid/ready on both sides.
// S1 holds accepted operands; S2 holds the computed result presented downstream.
import alu_pkg::*;

module alu_pipe #(
   parameter int WIDTH = ALU_WIDTH,
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] dataA_i,
   input  logic [WIDTH-1:0] dataB_i,
   input  logic [2:0]       ALUCtrl_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] ALUResult_o,
   output logic             Zero_o,
   output logic             Ovf_o,
   output logic [CNT_W-1:0] ops_done_o
);

   logic             s1_valid;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   alu_op_e          s1_op;

   logic             s2_valid;
   alu_res_t         s2_res;
   alu_res_t         core_res;

   logic             in_fire;
   logic             out_fire;
   logic             s2_load;

   // Handshake and stage-advance terms. in_ready ignores in_valid so the
   // upstream can use it without a combinational loop.
   always_comb begin
      in_ready_o = !rst_i && (!s1_valid || !s2_valid || out_ready_i);
      in_fire    = in_valid_i && in_ready_o;
      out_fire   = s2_valid && out_ready_i;
      s2_load    = s1_valid && (!s2_valid || out_ready_i);
   end

   alu_core u_core (
      .a   (s1_a),
      .b   (s1_b),
      .op  (s1_op),
      .res (core_res)
   );

   // Stage 1: capture operands on accept; empties when it moves into S2.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_op    <= OP_AND;
      end else if (in_fire) begin
         s1_valid <= 1'b1;
         s1_a     <= dataA_i;
         s1_b     <= dataB_i;
         s1_op    <= alu_op_e'(ALUCtrl_i);
      end else if (s2_load) begin
         s1_valid <= 1'b0;
      end
   end

   // Stage 2: register the computed result; held untouched under backpressure.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s2_valid <= 1'b0;
         s2_res   <= '0;
      end else if (s2_load) begin
         s2_valid <= 1'b1;
         s2_res   <= core_res;
      end else if (out_fire) begin
         s2_valid <= 1'b0;
      end
   end

   // Completed-operation counter, wraps silently.
   always_ff @(posedge clk_i) begin
      if (rst_i)
         ops_done_o <= '0;
      else if (out_fire)
         ops_done_o <= ops_done_o + 1'b1;
   end

   // Output fields come straight from S2 so they cannot change while stalled.
   always_comb begin
      out_valid_o = s2_valid;
      ALUResult_o = s2_res.result;
      Zero_o      = s2_res.zero;
      Ovf_o       = s2_res.ovf;
   end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed and randomized bench for alu_pipe.
module tb_alu_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic [2:0]  ctrl;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        zero;
   logic        ovf;
   logic [15:0] ops_done;

   int checks = 0;
   int errors = 0;

   localparam longint MAXS = 64'sd2147483647;
   localparam longint MINS = -(64'sd2147483648);

   always #5 clk = ~clk;

   alu_pipe #(.WIDTH(32), .CNT_W(16)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .dataA_i     (a),
      .dataB_i     (b),
      .ALUCtrl_i   (ctrl),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .ALUResult_o (result),
      .Zero_o      (zero),
      .Ovf_o       (ovf),
      .ops_done_o  (ops_done)
   );

   // Reference model: {ovf, zero, result}, overflow from 64-bit signed math.
   function automatic logic [33:0] ref_alu(input logic [31:0] x, input logic [31:0] y,
                                           input logic [2:0] op);
      longint sx, sy, s;
      logic [31:0] r;
      logic o;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      o  = 1'b0;
      r  = '0;
      case (op)
         3'd0: r = x & y;
         3'd1: r = x | y;
         3'd2: begin s = sx + sy; r = x + y; o = (s > MAXS) || (s < MINS); end
         3'd3: r = x ^ y;
         3'd4: r = ~(x | y);
         3'd5: r = (x < y) ? 32'd1 : 32'd0;
         3'd6: begin s = sx - sy; r = x - y; o = (s > MAXS) || (s < MINS); end
         default: r = (sx < sy) ? 32'd1 : 32'd0;
      endcase
      return {o, (r == 32'd0), r};
   endfunction

   // Drive one op with out_ready high and capture the result and its latency.
   task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic [2:0] top,
                         output logic [31:0] r, output logic z, output logic o, output int lat);
      int g;
      @(negedge clk);
      in_valid = 1'b1; a = ta; b = tb_v; ctrl = top; out_ready = 1'b1;
      #1;
      g = 0;
      while (!in_ready && g < 20) begin @(negedge clk); #1; g++; end
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      #1;
      while (!out_valid && lat < 20) begin @(negedge clk); #1; lat++; end
      r = result; z = zero; o = ovf;
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; ctrl = '0;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
      checks++; if (zero !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL reset_flags: got z=%b o=%b want 0 0", zero, ovf); end
      checks++; if (ops_done !== 16'h0) begin errors++; $display("FAIL reset_ops_done: got %0d want 0", ops_done); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_single();
      logic [31:0] r; logic z, o; int lat;
      run_op(32'h5, 32'h3, 3'b010, r, z, o, lat);
      checks++; if (lat !== 2) begin errors++; $display("FAIL single_latency: got %0d want 2", lat); end
      checks++; if (r !== 32'h8) begin errors++; $display("FAIL single_result: got %h want 8", r); end
      checks++; if (z !== 1'b0 || o !== 1'b0) begin errors++; $display("FAIL single_flags: got z=%b o=%b want 0 0", z, o); end
      checks++; if (ops_done !== 16'd1) begin errors++; $display("FAIL single_ops_done: got %0d want 1", ops_done); end
   endtask

   task automatic test_flags();
      logic [31:0] va[7] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h1234, 32'hF0F0_F0F0, 32'h0000_F000, 32'hA5A5_A5A5, 32'hFFFF_FFFF};
      logic [31:0] vb[7] = '{32'h1,         32'h1,         32'h1234, 32'h0FF0_0FF0, 32'h0000_000F, 32'hA5A5_A5A5, 32'h1};
      logic [2:0]  vo[7] = '{3'b010,        3'b110,        3'b110,   3'b000,        3'b001,        3'b011,        3'b010};
      logic [31:0] er[7] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h0,    32'h00F0_00F0, 32'h0000_F00F, 32'h0,         32'h0};
      logic        ez[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      logic        eo[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      logic [31:0] r; logic z, o; int lat;
      for (int i = 0; i < 7; i++) begin
         run_op(va[i], vb[i], vo[i], r, z, o, lat);
         checks++; if (r !== er[i]) begin errors++; $display("FAIL flags_result[%0d]: got %h want %h", i, r, er[i]); end
         checks++; if (z !== ez[i]) begin errors++; $display("FAIL flags_zero[%0d]: got %b want %b", i, z, ez[i]); end
         checks++; if (o !== eo[i]) begin errors++; $display("FAIL flags_ovf[%0d]: got %b want %b", i, o, eo[i]); end
      end
   endtask

   task automatic test_compares();
      logic [31:0] va[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'h1,         32'h1};
      logic [31:0] vb[5] = '{32'h1,         32'h1,         32'h0,         32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [2:0]  vo[5] = '{3'b111,        3'b101,        3'b100,        3'b111,        3'b101};
      logic [31:0] er[5] = '{32'h1,         32'h0,         32'hFFFF_FFFF, 32'h0,         32'h1};
      logic        ez[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [31:0] r; logic z, o; int lat;
      for (int i = 0; i < 5; i++) begin
         run_op(va[i], vb[i], vo[i], r, z, o, lat);
         checks++; if (r !== er[i]) begin errors++; $display("FAIL cmp_result[%0d]: got %h want %h", i, r, er[i]); end
         checks++; if (z !== ez[i] || o !== 1'b0) begin errors++; $display("FAIL cmp_flags[%0d]: got z=%b o=%b want z=%b o=0", i, z, o, ez[i]); end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] va[4] = '{32'd1, 32'd10, 32'hF0, 32'h100};
      logic [31:0] vb[4] = '{32'd2, 32'd4,  32'hFF, 32'h1};
      logic [2:0]  vo[4] = '{3'b010, 3'b110, 3'b011, 3'b001};
      logic [31:0] er[4] = '{32'd3, 32'd6,  32'h0F, 32'h101};
      int in_idx, out_idx, first, last;
      logic [15:0] base;
      in_idx = 0; out_idx = 0; first = -1; last = -1;
      base = ops_done;
      for (int cyc = 0; cyc < 30 && out_idx < 4; cyc++) begin
         @(negedge clk);
         out_ready = (cyc >= 5);
         in_valid  = (in_idx < 4);
         if (in_idx < 4) begin a = va[in_idx]; b = vb[in_idx]; ctrl = vo[in_idx]; end
         #1;
         if (cyc == 2) begin
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_full: got %b want 0", in_ready); end
            checks++; if (in_idx !== 2) begin errors++; $display("FAIL bp_accepts_before_stall: got %0d want 2", in_idx); end
         end
         if (cyc >= 2 && cyc <= 4) begin
            checks++; if (out_valid !== 1'b1 || result !== 32'd3) begin errors++; $display("FAIL bp_hold[%0d]: got v=%b r=%h want v=1 r=3", cyc, out_valid, result); end
         end
         if (out_valid && out_ready) begin
            checks++; if (result !== er[out_idx]) begin errors++; $display("FAIL bp_order[%0d]: got %h want %h", out_idx, result, er[out_idx]); end
            if (first < 0) first = cyc;
            last = cyc;
            out_idx++;
         end
         if (in_valid && in_ready) in_idx++;
      end
      in_valid = 1'b0;
      checks++; if (out_idx !== 4) begin errors++; $display("FAIL bp_drain_count: got %0d want 4", out_idx); end
      checks++; if (last - first !== 3) begin errors++; $display("FAIL bp_back_to_back: got span %0d want 3", last - first); end
      @(negedge clk);
      #1;
      checks++; if (ops_done !== 16'(base + 16'd4)) begin errors++; $display("FAIL bp_ops_done: got %0d want %0d", ops_done, 16'(base + 16'd4)); end
   endtask

   task automatic test_reset_midflight();
      logic seen;
      out_ready = 1'b0;
      @(negedge clk); in_valid = 1'b1; a = 32'd1; b = 32'd1; ctrl = 3'b010;
      @(negedge clk); a = 32'd2; b = 32'd2;
      @(negedge clk); in_valid = 1'b0; rst = 1'b1; out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_in_ready: got %b want 0", in_ready); end
      @(negedge clk); rst = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid: got %b want 0", out_valid); end
      checks++; if (ops_done !== 16'd0) begin errors++; $display("FAIL rst_mid_ops_done: got %0d want 0", ops_done); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_release_ready: got %b want 1", in_ready); end
      seen = 1'b0;
      repeat (4) begin @(negedge clk); #1; if (out_valid) seen = 1'b1; end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_mid_ghost: got out_valid after reset want none"); end
   endtask

   task automatic test_random();
      localparam int N = 3000;
      logic [33:0] q[$];
      logic [33:0] e;
      logic [15:0] base;
      logic pend;
      int sent, recv, cyc;
      sent = 0; recv = 0; cyc = 0; pend = 1'b0;
      base = ops_done;
      in_valid = 1'b0; out_ready = 1'b0;
      while (recv < N && cyc < 40000) begin
         @(negedge clk);
         cyc++;
         if (!pend && sent < N && $urandom_range(0, 1) == 1) begin
            a = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'h7FFF_FFFF) : $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            ctrl = 3'($urandom_range(0, 7));
            pend = 1'b1;
         end
         in_valid  = pend;
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               checks++; errors++; $display("FAIL rnd_extra_output: got %h want nothing", result);
            end else begin
               e = q.pop_front();
               checks++; if ({ovf, zero, result} !== e) begin errors++; $display("FAIL rnd_data[%0d]: got %h want %h", recv, {ovf, zero, result}, e); end
            end
            recv++;
         end
         if (in_valid && in_ready) begin
            q.push_back(ref_alu(a, b, ctrl));
            sent++;
            pend = 1'b0;
         end
      end
      in_valid = 1'b0;
      @(negedge clk);
      #1;
      checks++; if (recv !== N || q.size() !== 0) begin errors++; $display("FAIL rnd_complete: got recv=%0d left=%0d want %0d 0", recv, q.size(), N); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rnd_dup: got out_valid=%b want 0", out_valid); end
      checks++; if (ops_done !== 16'(base + 16'(N))) begin errors++; $display("FAIL rnd_ops_done: got %0d want %0d", ops_done, 16'(base + 16'(N))); end
   endtask

   task automatic test_wrap();
      int rem, sent, recv, cyc;
      logic saw_max;
      rem = 65536 - int'(ops_done);
      sent = 0; recv = 0; cyc = 0; saw_max = 1'b0;
      ctrl = 3'b010; b = 32'd1;
      while (recv < rem && cyc < rem + 50) begin
         @(negedge clk);
         cyc++;
         in_valid = (sent < rem);
         a = 32'(sent);
         out_ready = 1'b1;
         #1;
         if (ops_done == 16'hFFFF) saw_max = 1'b1;
         if (out_valid && out_ready) recv++;
         if (in_valid && in_ready) sent++;
      end
      in_valid = 1'b0;
      @(negedge clk);
      #1;
      checks++; if (recv !== rem) begin errors++; $display("FAIL wrap_count: got %0d want %0d", recv, rem); end
      checks++; if (saw_max !== 1'b1) begin errors++; $display("FAIL wrap_max_seen: got %b want 1", saw_max); end
      checks++; if (ops_done !== 16'd0) begin errors++; $display("FAIL wrap_ops_done: got %0d want 0", ops_done); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_flags();
      test_compares();
      test_backpressure();
      test_reset_midflight();
      test_random();
      test_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
